mem_bridge: RTL and testbench

- Sits between the tiny8 datapath/control and physical memory.
- Accepts one CPU read or write at a time and drives a variable-latency physical-memory handshake.
- Returns a one-cycle mem_resp pulse, which is the mem_resp consumed by the control FSM in its fetch and memory states.
- Holds a one-entry read buffer (last address/data) so repeated reads of the same address complete without a physical access.

---
 rtl/tiny8_types.sv | 17 +
 rtl/mem_line_buf.sv | 39 +++
 rtl/mem_bridge.sv | 93 +++++++++
 tb/tb_mem_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tiny8_types.sv
// Shared tiny8 types: datapath words, addresses and the memory-bridge state.
package tiny8_types;

   localparam int TINY8_ADDR_W = 8;
   localparam int TINY8_DATA_W = 8;

   typedef logic [TINY8_DATA_W-1:0] tiny8_word;
   typedef logic [TINY8_ADDR_W-1:0] tiny8_addr;

   typedef enum logic [1:0] {
      MB_IDLE,
      MB_PMEM,
      MB_RESP,
      MB_HIT
   } mem_bridge_state;

endpackage

// File: rtl/mem_line_buf.sv
// One-entry read buffer: remembers the last address/data seen by the bridge.
module mem_line_buf
   import tiny8_types::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int BUF_EN = 1
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              load,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic [ADDR_W-1:0] look_addr,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data
);

   logic              valid;
   logic [ADDR_W-1:0] tag;
   logic [DATA_W-1:0] word;

   // With the buffer disabled the entry never becomes valid, so no hit.
   always_ff @(posedge clk) begin
      if (clear) begin
         valid <= 1'b0;
         tag   <= '0;
         word  <= '0;
      end else if (load) begin
         valid <= (BUF_EN != 0);
         tag   <= addr;
         word  <= data;
      end
   end

   assign hit      = valid && (tag == look_addr);
   assign hit_data = word;

endmodule

// File: rtl/mem_bridge.sv
// CPU-to-physical memory bridge: one request at a time, one-entry read buffer.
module mem_bridge
   import tiny8_types::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int BUF_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_resp,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [DATA_W-1:0] pmem_wdata,
   input  logic              pmem_resp,
   input  logic [DATA_W-1:0] pmem_rdata
);

   mem_bridge_state   state;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wr_q;
   logic              buf_hit;
   logic              buf_load;
   logic [DATA_W-1:0] buf_data;
   logic [DATA_W-1:0] buf_din;

   // Write-allocate: a completed write also refreshes the buffer.
   assign buf_load = (state == MB_PMEM) && pmem_resp;
   assign buf_din  = wr_q ? wdata_q : pmem_rdata;

   mem_line_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .BUF_EN (BUF_EN)
   ) u_buf (
      .clk       (clk),
      .clear     (rst),
      .load      (buf_load),
      .addr      (addr_q),
      .data      (buf_din),
      .look_addr (mem_address),
      .hit       (buf_hit),
      .hit_data  (buf_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= MB_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         mem_rdata <= '0;
      end else begin
         unique case (state)
            MB_IDLE: begin
               if (mem_read || mem_write) begin
                  addr_q  <= mem_address;
                  wdata_q <= mem_wdata;
                  wr_q    <= mem_write;
                  if (!mem_write && buf_hit) begin
                     state     <= MB_HIT;
                     mem_rdata <= buf_data;
                  end else begin
                     state <= MB_PMEM;
                  end
               end
            end
            MB_PMEM: begin
               if (pmem_resp) begin
                  state <= MB_RESP;
                  if (!wr_q) mem_rdata <= pmem_rdata;
               end
            end
            MB_RESP, MB_HIT: state <= MB_IDLE;
            default:         state <= MB_IDLE;
         endcase
      end
   end

   assign mem_resp     = (state == MB_RESP) || (state == MB_HIT);
   assign pmem_read    = (state == MB_PMEM) && !wr_q;
   assign pmem_write   = (state == MB_PMEM) && wr_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: buffered instance plus a BUF_EN=0 instance.
module tb_mem_bridge;

   logic       clk = 1'b0;
   logic       rst;
   logic       mem_read, mem_write;
   logic [7:0] mem_address, mem_wdata;
   logic       mem_resp;
   logic [7:0] mem_rdata;
   logic       pmem_read, pmem_write;
   logic [7:0] pmem_address, pmem_wdata;
   logic       pmem_resp;
   logic [7:0] pmem_rdata;

   logic       r1;
   logic [7:0] a1;
   logic       resp1;
   logic [7:0] rdata1;
   logic       pread1, pwrite1;
   logic [7:0] paddr1, pwdata1;
   logic       presp1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_bridge #(.ADDR_W(8), .DATA_W(8), .BUF_EN(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_resp     (mem_resp),
      .mem_rdata    (mem_rdata),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_resp    (pmem_resp),
      .pmem_rdata   (pmem_rdata)
   );

   mem_bridge #(.ADDR_W(8), .DATA_W(8), .BUF_EN(0)) dut_nobuf (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (r1),
      .mem_write    (1'b0),
      .mem_address  (a1),
      .mem_wdata    (8'h00),
      .mem_resp     (resp1),
      .mem_rdata    (rdata1),
      .pmem_read    (pread1),
      .pmem_write   (pwrite1),
      .pmem_address (paddr1),
      .pmem_wdata   (pwdata1),
      .pmem_resp    (presp1),
      .pmem_rdata   (pmem_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
      mem_address = 8'h10; mem_wdata = 8'h00;
      pmem_resp = 1'b0; pmem_rdata = 8'h00;
      r1 = 1'b0; a1 = 8'h00; presp1 = 1'b0;

      // reset held two cycles with a read pending
      tick();
      chk("rst_resp", {7'd0, mem_resp}, 8'h00);
      chk("rst_rdata", mem_rdata, 8'h00);
      chk("rst_pread", {7'd0, pmem_read}, 8'h00);
      chk("rst_pwrite", {7'd0, pmem_write}, 8'h00);
      chk("rst_paddr", pmem_address, 8'h00);
      chk("rst_pwdata", pmem_wdata, 8'h00);
      tick();
      chk("rst2_resp", {7'd0, mem_resp}, 8'h00);
      chk("rst2_pread", {7'd0, pmem_read}, 8'h00);
      rst = 1'b0; mem_read = 1'b0;
      tick();

      // read miss 0x10, memory answers in the third PMEM cycle
      mem_read = 1'b1; mem_address = 8'h10;
      tick();
      chk("miss_pread_c1", {7'd0, pmem_read}, 8'h01);
      chk("miss_paddr", pmem_address, 8'h10);
      chk("miss_noresp_c1", {7'd0, mem_resp}, 8'h00);
      tick();
      chk("miss_pread_c2", {7'd0, pmem_read}, 8'h01);
      tick();
      chk("miss_pread_c3", {7'd0, pmem_read}, 8'h01);
      chk("miss_noresp_c3", {7'd0, mem_resp}, 8'h00);
      pmem_resp = 1'b1; pmem_rdata = 8'hA5;
      tick();
      pmem_resp = 1'b0;
      chk("miss_resp", {7'd0, mem_resp}, 8'h01);
      chk("miss_rdata", mem_rdata, 8'hA5);
      chk("miss_pread_drop", {7'd0, pmem_read}, 8'h00);
      mem_read = 1'b0;
      tick();
      chk("miss_resp_once", {7'd0, mem_resp}, 8'h00);
      chk("miss_rdata_held", mem_rdata, 8'hA5);

      // repeat read of 0x10 hits the buffer
      mem_read = 1'b1;
      tick();
      chk("hit_resp", {7'd0, mem_resp}, 8'h01);
      chk("hit_rdata", mem_rdata, 8'hA5);
      chk("hit_no_pread", {7'd0, pmem_read}, 8'h00);
      mem_read = 1'b0;
      tick();
      chk("hit_resp_once", {7'd0, mem_resp}, 8'h00);

      // write 0x3C to 0x10, then read it back from the buffer
      mem_write = 1'b1; mem_wdata = 8'h3C;
      tick();
      chk("wr_pwrite", {7'd0, pmem_write}, 8'h01);
      chk("wr_no_pread", {7'd0, pmem_read}, 8'h00);
      chk("wr_pwdata", pmem_wdata, 8'h3C);
      chk("wr_paddr", pmem_address, 8'h10);
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      chk("wr_resp", {7'd0, mem_resp}, 8'h01);
      chk("wr_rdata_kept", mem_rdata, 8'hA5);
      chk("wr_pwrite_drop", {7'd0, pmem_write}, 8'h00);
      mem_write = 1'b0;
      tick();
      mem_read = 1'b1;
      tick();
      chk("wrhit_resp", {7'd0, mem_resp}, 8'h01);
      chk("wrhit_rdata", mem_rdata, 8'h3C);
      chk("wrhit_no_pread", {7'd0, pmem_read}, 8'h00);
      mem_read = 1'b0;
      tick();

      // miss 0x20, address changes mid-wait, reset abandons it
      mem_read = 1'b1; mem_address = 8'h20;
      tick();
      chk("ab_pread", {7'd0, pmem_read}, 8'h01);
      chk("ab_paddr1", pmem_address, 8'h20);
      mem_address = 8'h30;
      tick();
      chk("ab_paddr2", pmem_address, 8'h20);
      chk("ab_pread2", {7'd0, pmem_read}, 8'h01);
      rst = 1'b1; mem_read = 1'b0;
      tick();
      chk("ab_rst_pread", {7'd0, pmem_read}, 8'h00);
      chk("ab_rst_paddr", pmem_address, 8'h00);
      chk("ab_rst_rdata", mem_rdata, 8'h00);
      rst = 1'b0; pmem_resp = 1'b1; pmem_rdata = 8'hEE;
      tick();
      pmem_resp = 1'b0;
      chk("late_resp_ignored", {7'd0, mem_resp}, 8'h00);
      chk("late_rdata_ignored", mem_rdata, 8'h00);
      mem_read = 1'b1; mem_address = 8'h10;
      tick();
      chk("postrst_miss", {7'd0, pmem_read}, 8'h01);
      chk("postrst_noresp", {7'd0, mem_resp}, 8'h00);
      pmem_resp = 1'b1; pmem_rdata = 8'h3C;
      tick();
      pmem_resp = 1'b0;
      chk("postrst_resp", {7'd0, mem_resp}, 8'h01);
      chk("postrst_rdata", mem_rdata, 8'h3C);
      mem_read = 1'b0;
      tick();

      // read and write together count as a write
      mem_read = 1'b1; mem_write = 1'b1;
      mem_address = 8'h05; mem_wdata = 8'h77;
      tick();
      chk("rw_pwrite", {7'd0, pmem_write}, 8'h01);
      chk("rw_no_pread", {7'd0, pmem_read}, 8'h00);
      chk("rw_paddr", pmem_address, 8'h05);
      chk("rw_pwdata", pmem_wdata, 8'h77);
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      chk("rw_resp", {7'd0, mem_resp}, 8'h01);
      mem_read = 1'b0; mem_write = 1'b0;
      tick();
      chk("rw_resp_once", {7'd0, mem_resp}, 8'h00);
      mem_read = 1'b1;
      tick();
      chk("rw_alloc_hit", {7'd0, mem_resp}, 8'h01);
      chk("rw_alloc_rdata", mem_rdata, 8'h77);
      mem_read = 1'b0;
      tick();

      // unbuffered instance: every read of 0x05 goes to memory
      r1 = 1'b1; a1 = 8'h05;
      tick();
      chk("nb_pread1", {7'd0, pread1}, 8'h01);
      chk("nb_paddr1", paddr1, 8'h05);
      presp1 = 1'b1; pmem_rdata = 8'h42;
      tick();
      presp1 = 1'b0;
      chk("nb_resp1", {7'd0, resp1}, 8'h01);
      chk("nb_rdata1", rdata1, 8'h42);
      r1 = 1'b0;
      tick();
      r1 = 1'b1;
      tick();
      chk("nb_pread2", {7'd0, pread1}, 8'h01);
      chk("nb_noresp2", {7'd0, resp1}, 8'h00);
      presp1 = 1'b1; pmem_rdata = 8'h43;
      tick();
      presp1 = 1'b0;
      chk("nb_resp2", {7'd0, resp1}, 8'h01);
      chk("nb_rdata2", rdata1, 8'h43);
      chk("nb_pwrite_never", {7'd0, pwrite1}, 8'h00);
      r1 = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
